// File: rtl/fetch.sv
// -----------------------------------------------------------------------------
// fetch
// Instruction fetch stage sitting directly in front of decode. It owns the
// program counter, issues in-order 32-bit reads to the instruction memory,
// tags each response with the PC of its request, and buffers {pc, instr}
// pairs in a small FIFO that decode drains over a valid/ready handshake.
// A redirect empties the buffer, marks every in-flight read as stale and
// restarts fetch at the new PC.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   imem_req_o            read request valid
//   imem_addr_o           read address (current pc, always word aligned)
//   imem_gnt_i            request accepted this cycle
//   imem_rvalid_i         in-order response valid
//   imem_rdata_i          response instruction word
//   redirect_i            flush and restart fetch
//   redirect_pc_i         restart address (bits [1:0] ignored)
//   instr_valid_o         buffer head valid toward decode
//   instr_ready_i         decode accepts the head this cycle
//   instr_o, pc_o         head instruction and its pc (zero when not valid)
// -----------------------------------------------------------------------------
module fetch #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_o,
  output logic [63:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [63:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o
);

  localparam int unsigned   CW       = $clog2(DEPTH + 1);
  localparam int unsigned   AW       = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [CW:0]   DEPTH_W  = (CW + 1)'(DEPTH);

  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] fifoCnt_q, fifoCnt_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] dropCnt_q, dropCnt_d;
  logic [AW-1:0] fifoHead_q, fifoHead_d, fifoTail_q, fifoTail_d;
  logic [AW-1:0] pcqHead_q, pcqHead_d, pcqTail_q, pcqTail_d;

  logic [63:0]   fifoPc    [DEPTH];
  logic [31:0]   fifoInstr [DEPTH];
  logic [63:0]   pcq       [DEPTH];

  logic grant, rspValid, push, pop;

  function automatic logic [AW-1:0] nextIdx(input logic [AW-1:0] idx);
    return (idx == LAST_IDX) ? '0 : idx + AW'(1);
  endfunction

  // Credit check counts stale in-flight reads too, so the FIFO can never be
  // asked to take more than DEPTH entries. Requests are held off while reset
  // is asserted so the first request appears only after it is released.
  assign imem_req_o  = !reset && !redirect_i &&
                       (((CW + 1)'(outstanding_q) + (CW + 1)'(fifoCnt_q)) < DEPTH_W);
  assign imem_addr_o = pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // A response with nothing outstanding is a protocol error and is ignored.
  // Responses are kept only when no stale reads remain and no redirect is
  // happening in the same cycle.
  assign rspValid = imem_rvalid_i && (outstanding_q != '0);
  assign push     = rspValid && (dropCnt_q == '0) && !redirect_i;

  assign instr_valid_o = (fifoCnt_q != '0) && !redirect_i;
  assign pop           = instr_valid_o && instr_ready_i;
  assign instr_o       = instr_valid_o ? fifoInstr[fifoHead_q] : '0;
  assign pc_o          = instr_valid_o ? fifoPc[fifoHead_q]    : 64'd0;

  // Next-state logic for pc, counters and queue pointers. On a redirect every
  // read still in flight becomes stale, including those already marked stale
  // by an earlier redirect, so the drop count is simply what remains
  // outstanding after this cycle's response. That keeps back-to-back
  // redirects from double counting.
  always_comb begin
    pc_d          = pc_q;
    fifoCnt_d     = fifoCnt_q;
    dropCnt_d     = dropCnt_q;
    fifoHead_d    = fifoHead_q;
    fifoTail_d    = fifoTail_q;
    pcqHead_d     = pcqHead_q;
    pcqTail_d     = pcqTail_q;
    outstanding_d = outstanding_q + CW'(grant) - CW'(rspValid);

    if (redirect_i) begin
      pc_d       = redirect_pc_i & ~64'h3;
      fifoCnt_d  = '0;
      fifoHead_d = '0;
      fifoTail_d = '0;
      pcqHead_d  = '0;
      pcqTail_d  = '0;
      dropCnt_d  = outstanding_q - CW'(rspValid);
    end else begin
      if (grant) begin
        pc_d      = pc_q + 64'd4;
        pcqTail_d = nextIdx(pcqTail_q);
      end
      if (rspValid && (dropCnt_q != '0)) begin
        dropCnt_d = dropCnt_q - CW'(1);
      end
      if (push) begin
        fifoTail_d = nextIdx(fifoTail_q);
        pcqHead_d  = nextIdx(pcqHead_q);
      end
      if (pop) begin
        fifoHead_d = nextIdx(fifoHead_q);
      end
      fifoCnt_d = fifoCnt_q + CW'(push) - CW'(pop);
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      fifoCnt_q     <= '0;
      outstanding_q <= '0;
      dropCnt_q     <= '0;
      fifoHead_q    <= '0;
      fifoTail_q    <= '0;
      pcqHead_q     <= '0;
      pcqTail_q     <= '0;
    end else begin
      pc_q          <= pc_d;
      fifoCnt_q     <= fifoCnt_d;
      outstanding_q <= outstanding_d;
      dropCnt_q     <= dropCnt_d;
      fifoHead_q    <= fifoHead_d;
      fifoTail_q    <= fifoTail_d;
      pcqHead_q     <= pcqHead_d;
      pcqTail_q     <= pcqTail_d;
    end
  end

  // Data storage needs no reset: entries are only read once the pointers and
  // counts say they were written. A grant and a kept response never touch the
  // same PC-queue slot because the credit rule stops grants when it is full.
  always_ff @(posedge clk) begin
    if (grant) begin
      pcq[pcqTail_q] <= pc_q;
    end
    if (push) begin
      fifoPc[fifoTail_q]    <= pcq[pcqHead_q];
      fifoInstr[fifoTail_q] <= imem_rdata_i;
    end
  end

endmodule
